ic1337_exerciser: RTL and testbench



---
 rtl/ic1337_pkg.sv | 23 ++
 rtl/ic1337_vec_seq.sv | 64 ++++++
 rtl/ic1337_exerciser.sv | 114 +++++++++++
 tb/tb_ic1337_exerciser.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ic1337_pkg.sv
`default_nettype none
// ============================================================================
// ic1337_pkg : shared state encoding, widths and Gray mapping for the exerciser
// Revision   : 1.0
// ============================================================================
package ic1337_pkg;

    localparam int NUM_STEPS = 8;
    localparam int VEC_W     = 3;
    localparam int SIG_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic [VEC_W-1:0] gray_map(input logic [VEC_W-1:0] n);
        return n ^ (n >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ic1337_vec_seq.sv
`default_nettype none
// ============================================================================
// ic1337_vec_seq : step/hold counters and binary-or-Gray vector generation
// Revision       : 1.0
// ============================================================================
module ic1337_vec_seq
    import ic1337_pkg::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             run,
    input  logic             mode,
    output logic [VEC_W-1:0] vec,
    output logic [2:0]       step,
    output logic             capture_pulse,
    output logic             last_step
);

    localparam logic [7:0] C_HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [2:0] C_STEP_LAST = 3'(NUM_STEPS - 1);

    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [2:0] step_q,     step_d;
    logic       mode_q,     mode_d;

    assign capture_pulse = run && (hold_cnt_q == C_HOLD_LAST);
    assign last_step     = (step_q == C_STEP_LAST);
    assign step          = step_q;
    assign vec           = mode_q ? gray_map(step_q) : step_q;

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        step_d     = step_q;
        mode_d     = mode_q;
        if (clear) begin
            hold_cnt_d = 8'd0;
            step_d     = 3'd0;
            mode_d     = mode;
        end else if (capture_pulse) begin
            // The step counter only wraps as the run finishes.
            hold_cnt_d = 8'd0;
            step_d     = last_step ? 3'd0 : step_q + 3'd1;
        end else if (run) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= 8'd0;
            step_q     <= 3'd0;
            mode_q     <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            step_q     <= step_d;
            mode_q     <= mode_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ic1337_exerciser.sv
`default_nettype none
// ============================================================================
// ic1337_exerciser : drives ic1337 through 8 vectors and hands the captured
//                    24-bit signature to a consumer over valid/ack
// Revision         : 1.0
// ============================================================================
module ic1337_exerciser
    import ic1337_pkg::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mode,
    input  logic        Q0,
    input  logic        Q1,
    input  logic        Z,
    output logic        I0,
    output logic        I1,
    output logic        I2,
    output logic        busy,
    output logic [2:0]  step_idx,
    output logic [23:0] result,
    output logic        result_valid,
    input  logic        result_ack
);

    state_e      state_q, state_d;
    logic [23:0] result_q, result_d;
    logic        result_valid_q, result_valid_d;

    logic             w_start_accept;
    logic             w_run;
    logic [VEC_W-1:0] w_vec;
    logic [2:0]       w_step;
    logic             w_capture;
    logic             w_last_step;

    assign w_run          = (state_q == ST_APPLY);
    assign w_start_accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    ic1337_vec_seq #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_vec_seq (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (w_start_accept),
        .run          (w_run),
        .mode         (mode),
        .vec          (w_vec),
        .step         (w_step),
        .capture_pulse(w_capture),
        .last_step    (w_last_step)
    );

    always_comb begin
        state_d        = state_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_APPLY;
                    result_d = 24'd0;
                end
            end
            ST_APPLY: begin
                if (w_capture) begin
                    result_d[int'(w_step) * SIG_W +: SIG_W] = {Z, Q1, Q0};
                    if (w_last_step) begin
                        state_d        = ST_DONE;
                        result_valid_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // A start here wins over ack: the new run begins immediately.
                if (start) begin
                    state_d        = ST_APPLY;
                    result_d       = 24'd0;
                    result_valid_d = 1'b0;
                end else if (result_ack) begin
                    state_d        = ST_IDLE;
                    result_valid_d = 1'b0;
                end
            end
            default: begin
                state_d        = ST_IDLE;
                result_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            result_q       <= 24'd0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign busy         = w_run;
    assign {I2, I1, I0} = w_run ? w_vec : 3'b000;
    assign step_idx     = w_step;
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_ic1337_exerciser.sv
`default_nettype none
// ============================================================================
// tb_ic1337_exerciser : two exercisers (hold 2 and hold 1) on loopback stubs
// Revision            : 1.0
// ============================================================================
module tb_ic1337_exerciser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic mode = 1'b0;
    logic result_ack = 1'b0;

    logic [2:0]  d0_i, d1_i, s0, s1, d0_step, d1_step;
    logic        d0_busy, d1_busy, d0_valid, d1_valid;
    logic [23:0] d0_res, d1_res;

    int total = 0;
    int bad = 0;

    ic1337_exerciser #(.HOLD_CYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .Q0(s0[0]), .Q1(s0[1]), .Z(s0[2]),
        .I0(d0_i[0]), .I1(d0_i[1]), .I2(d0_i[2]),
        .busy(d0_busy), .step_idx(d0_step), .result(d0_res),
        .result_valid(d0_valid), .result_ack(result_ack)
    );

    ic1337_exerciser #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .Q0(s1[0]), .Q1(s1[1]), .Z(s1[2]),
        .I0(d1_i[0]), .I1(d1_i[1]), .I2(d1_i[2]),
        .busy(d1_busy), .step_idx(d1_step), .result(d1_res),
        .result_valid(d1_valid), .result_ack(result_ack)
    );

    // Loopback stand-ins for ic1337: {Z,Q1,Q0} <= {I2,I1,I0}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0 <= 3'd0;
            s1 <= 3'd0;
        end else begin
            s0 <= d0_i;
            s1 <= d1_i;
        end
    end

    task automatic check(input string nm, input int d, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s dut%0d got=%h want=%h at %0t", nm, d, got, want, $time);
        end
    endtask

    function automatic logic [2:0] vec_of(input int n, input bit m);
        logic [2:0] v;
        v = 3'(n);
        return m ? (v ^ (v >> 1)) : v;
    endfunction

    // Signature after 'el' cycles of a run: slot n is captured at cycle (n+1)*h,
    // and the loopback shows the vector driven two cycles before that edge.
    function automatic logic [23:0] exp_res_f(input int el, input int h, input bit m);
        logic [23:0] r;
        int j;
        r = 24'd0;
        for (int n = 0; n < 8; n++) begin
            if ((n + 1) * h <= el) begin
                j = (n + 1) * h - 2;
                r[n*3 +: 3] = (j < 0) ? 3'd0 : vec_of(j / h, m);
            end
        end
        return r;
    endfunction

    int          hh [2] = '{2, 1};
    int          m_el [2];
    bit          m_run [2];
    bit          m_valid [2];
    bit          m_ml [2];
    logic [23:0] m_res [2];

    // Reference: a run is "cycles elapsed since start"; it completes at 8*h.
    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_el[d] = 0; m_run[d] = 0; m_valid[d] = 0; m_ml[d] = 0; m_res[d] = 24'd0;
            end else if (m_run[d]) begin
                m_el[d]++;
                if (m_el[d] == 8 * hh[d]) begin
                    m_run[d]   = 0;
                    m_valid[d] = 1;
                    m_res[d]   = exp_res_f(m_el[d], hh[d], m_ml[d]);
                end
            end else if (start) begin
                m_run[d] = 1; m_el[d] = 0; m_ml[d] = mode; m_valid[d] = 0; m_res[d] = 24'd0;
            end else if (m_valid[d] && result_ack) begin
                m_valid[d] = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [2:0] gi, gs;
        logic gb, gv;
        logic [23:0] gr;
        for (int d = 0; d < 2; d++) begin
            gi = d == 0 ? d0_i : d1_i;
            gs = d == 0 ? d0_step : d1_step;
            gb = d == 0 ? d0_busy : d1_busy;
            gv = d == 0 ? d0_valid : d1_valid;
            gr = d == 0 ? d0_res : d1_res;
            check("busy", d, 32'(gb), 32'(m_run[d]));
            check("vec", d, 32'(gi), 32'(m_run[d] ? vec_of(m_el[d] / hh[d], m_ml[d]) : 3'd0));
            check("step_idx", d, 32'(gs), m_run[d] ? 32'(m_el[d] / hh[d]) : 32'd0);
            check("result_valid", d, 32'(gv), 32'(m_valid[d]));
            check("result", d, 32'(gr), 32'(m_run[d] ? exp_res_f(m_el[d], hh[d], m_ml[d]) : m_res[d]));
        end
    end

    int n, n1;

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_result", 0, 32'(d0_res), 32'd0);
        check("reset_busy", 0, 32'(d0_busy), 32'd0);

        // Binary run with a start and an ack pulse dropped into APPLY.
        start = 1'b1; mode = 1'b0;
        @(negedge clk);
        start = 1'b0; n = 0; n1 = -1;
        while (!d0_valid && n < 100) begin
            start = (n == 3); result_ack = (n == 3);
            @(negedge clk);
            n++;
            if (d1_valid && n1 < 0) n1 = n;
        end
        start = 1'b0; result_ack = 1'b0;
        check("latency_h2", 0, 32'(n), 32'd16);
        check("latency_h1", 1, 32'(n1), 32'd8);
        check("sig_bin_h2", 0, 32'(d0_res), 32'h00FAC688);
        check("sig_bin_h1", 1, 32'(d1_res), 32'h00D63440);

        result_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        result_ack = 1'b0;
        check("ack_valid", 0, 32'(d0_valid), 32'd0);
        check("ack_keep", 0, 32'(d0_res), 32'h00FAC688);

        // Gray run.
        start = 1'b1; mode = 1'b1;
        @(negedge clk);
        start = 1'b0; mode = 1'b0; n = 0;
        while (!d0_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("latency_gray", 0, 32'(n), 32'd16);
        check("sig_gray_h2", 0, 32'(d0_res), 32'h0097E4C8);
        check("sig_gray_h1", 1, 32'(d1_res), 32'h00BF2640);

        // Start and ack together in DONE.
        start = 1'b1; result_ack = 1'b1; mode = 1'b0;
        @(negedge clk);
        start = 1'b0; result_ack = 1'b0;
        check("restart_valid", 0, 32'(d0_valid), 32'd0);
        check("restart_busy", 0, 32'(d0_busy), 32'd1);
        check("restart_result", 0, 32'(d0_res), 32'd0);
        check("restart_vec", 0, 32'(d0_i), 32'd0);

        // Asynchronous reset mid-run at step 4.
        n = 0;
        while (d0_step != 3'd4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_step4", 0, 32'(d0_step), 32'd4);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_vec", 0, 32'(d0_i), 32'd0);
        check("arst_busy", 0, 32'(d0_busy), 32'd0);
        check("arst_step", 0, 32'(d0_step), 32'd0);
        check("arst_result", 0, 32'(d0_res), 32'd0);
        check("arst_valid", 1, 32'(d1_valid), 32'd0);
        check("arst_result", 1, 32'(d1_res), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("no_valid_after_rst", 0, 32'(d0_valid), 32'd0);

        // Randomised traffic, including occasional asynchronous resets.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                start = 1'b0; result_ack = 1'b0;
                @(posedge clk);
                #2 rst_n = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                start      = ($urandom_range(0, 19) == 0);
                mode       = 1'($urandom_range(0, 1));
                result_ack = ($urandom_range(0, 3) == 0);
                @(negedge clk);
            end
        end
        start = 1'b0; result_ack = 1'b0;
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
